// File: rtl/seg_display_mux.sv
// Time-multiplexed DIGITS-wide seven-segment scanner with double-buffered hex/dp/blank data.
// Define LEADING_ZERO_BLANK_EN to also darken leading zero digits (digit 0 is always shown).
module seg_display_mux #(
  parameter int DIGITS     = 8,
  parameter int DIV        = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                load,
  output logic [DIGITS-1:0]   sel,
  output logic [7:0]          data,
  output logic                frame_start
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DIGITS-1:0] SEL_OFF    = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        DATA_OFF   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pend_value;
  logic [DIGITS-1:0]   r_pend_dp;
  logic [DIGITS-1:0]   r_pend_blank;
  logic [4*DIGITS-1:0] r_shadow_value;
  logic [DIGITS-1:0]   r_shadow_dp;
  logic [DIGITS-1:0]   r_shadow_blank;
  logic [DIGITS-1:0]   r_sel;
  logic [7:0]          r_data;
  logic                r_frame_start;

  logic                w_tick;
  logic                w_frame_edge;
  logic [4*DIGITS-1:0] w_src_value;
  logic [DIGITS-1:0]   w_src_dp;
  logic [DIGITS-1:0]   w_src_blank;
  logic [3:0]          w_nibble;
  logic                w_dp;
  logic                w_blank;
  logic                w_lz_blank;
  logic [DIGITS-1:0]   w_sel_hot;
  logic [6:0]          w_seg;
  logic [7:0]          w_data_hot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_frame_edge = (r_idx == '0);

  // Digit 0 decodes straight from pending so the new frame is visible on its very first slot.
  assign w_src_value = w_frame_edge ? r_pend_value : r_shadow_value;
  assign w_src_dp    = w_frame_edge ? r_pend_dp    : r_shadow_dp;
  assign w_src_blank = w_frame_edge ? r_pend_blank : r_shadow_blank;

  always_comb begin
    w_nibble  = 4'h0;
    w_dp      = 1'b0;
    w_blank   = 1'b0;
    w_sel_hot = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if (r_idx == IW'(j)) begin
        w_nibble     = w_src_value[4*j +: 4];
        w_dp         = w_src_dp[j];
        w_blank      = w_src_blank[j];
        w_sel_hot[j] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and everything above it is zero with no dp lit.
  always_comb begin
    w_lz_blank = (r_idx != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(r_idx)) && ((w_src_value[4*j +: 4] != 4'h0) || w_src_dp[j])) begin
        w_lz_blank = 1'b0;
      end
    end
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_seg      = hex_to_seg(w_nibble);
  assign w_data_hot = (w_blank || w_lz_blank) ? 8'h00 : {w_dp, w_seg};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc        <= '0;
      r_idx          <= '0;
      r_pend_value   <= '0;
      r_pend_dp      <= '0;
      r_pend_blank   <= '0;
      r_shadow_value <= '0;
      r_shadow_dp    <= '0;
      r_shadow_blank <= '0;
      r_sel          <= SEL_OFF;
      r_data         <= DATA_OFF;
      r_frame_start  <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + 1'b1;
      r_frame_start <= 1'b0;
      if (load) begin
        r_pend_value <= value_in;
        r_pend_dp    <= dp_in;
        r_pend_blank <= blank_in;
      end
      // A load on the frame-edge tick misses this frame because shadow copies the old pending.
      if (w_tick) begin
        if (w_frame_edge) begin
          r_shadow_value <= r_pend_value;
          r_shadow_dp    <= r_pend_dp;
          r_shadow_blank <= r_pend_blank;
        end
        r_sel         <= (ACTIVE_LOW != 0) ? ~w_sel_hot : w_sel_hot;
        r_data        <= (ACTIVE_LOW != 0) ? ~w_data_hot : w_data_hot;
        r_frame_start <= w_frame_edge;
        r_idx         <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign sel         = r_sel;
  assign data        = r_data;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux (DIGITS=4, DIV=4, ACTIVE_LOW=1, 10ns clock).
// Expected values come from a time-based behavioural model plus fixed constants.
module tb_seg_display_mux;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clock;
  logic        reset;
  logic [15:0] valueIn;
  logic [3:0]  dpIn;
  logic [3:0]  blankIn;
  logic        load;
  logic [3:0]  sel;
  logic [7:0]  data;
  logic        frameStart;

  int testsRun;
  int testsFailed;

  seg_display_mux #(
    .DIGITS(DIGITS),
    .DIV(DIV),
    .ACTIVE_LOW(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .value_in(valueIn),
    .dp_in(dpIn),
    .blank_in(blankIn),
    .load(load),
    .sel(sel),
    .data(data),
    .frame_start(frameStart)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected active-low segment byte for digit d of a {blank, dp, value} snapshot.
  function automatic logic [7:0] expSeg(input logic [23:0] snap, input int d);
    logic [3:0] nib;
    logic [6:0] seg;
    logic       blk;
    nib = snap[4*d +: 4];
    blk = snap[20+d];
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      logic allZero;
      allZero = 1'b1;
      for (int j = d; j < DIGITS; j++)
        if (snap[4*j +: 4] != 4'h0 || snap[16+j]) allZero = 1'b0;
      if (allZero) blk = 1'b1;
    end
`endif
    if (blk) return 8'hFF;
    return ~{snap[16+d], seg};
  endfunction

  // Reference model: counts posedges since reset release; every DIV-th one starts the next digit slot.
  logic [23:0] mPending, mShadow;
  logic [3:0]  mSel;
  logic [7:0]  mData;
  logic        mFs;
  int          mT, mDigit;

  always @(posedge clock) begin
    if (reset) begin
      mT = 0; mPending = '0; mShadow = '0;
      mSel = 4'hF; mData = 8'hFF; mFs = 1'b0;
    end else begin
      mT  = mT + 1;
      mFs = 1'b0;
      if (mT % DIV == 0) begin
        mDigit = (mT / DIV - 1) % DIGITS;
        if (mDigit == 0) mShadow = mPending;
        mSel  = ~(4'b0001 << mDigit);
        mData = expSeg(mShadow, mDigit);
        mFs   = (mDigit == 0);
      end
      if (load) mPending = {blankIn, dpIn, valueIn};
    end
  end

  task automatic doLoad(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blk);
    @(negedge clock);
    valueIn = v; dpIn = dp; blankIn = blk; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic waitFrameStart(output bit found);
    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clock);
      if (frameStart === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; valueIn = '0; dpIn = '0; blankIn = '0;
    @(negedge clock);
    testsRun++;
    if (sel !== 4'hF || data !== 8'hFF || frameStart !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state sel=%h data=%h fs=%b required sel=f data=ff fs=0", sel, data, frameStart);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      testsRun++;
      if (sel !== 4'hF || data !== 8'hFF || frameStart !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL pre_tick_off cycle=%0d sel=%h data=%h fs=%b required sel=f data=ff fs=0", k, sel, data, frameStart);
      end
    end
    @(negedge clock);
    testsRun++;
    if (sel !== 4'b1110 || frameStart !== 1'b1 || data !== 8'hC0) begin
      testsFailed++;
      $display("[TB] FAIL first_tick sel=%b fs=%b data=%h required sel=1110 fs=1 data=c0", sel, frameStart, data);
    end
    @(negedge clock);
    testsRun++;
    if (frameStart !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL fs_one_cycle fs=%b required 0", frameStart);
    end
  endtask

  // Loads a snapshot, lets one frame pass, then checks a whole frame against fixed per-digit bytes.
  task automatic test_frame(input string name, input logic [15:0] v, input logic [3:0] dp,
                            input logic [3:0] blk, input logic [31:0] expBytes);
    bit found;
    logic [3:0] eSel;
    logic [7:0] eData;
    doLoad(v, dp, blk);
    for (int f = 0; f < 2; f++) begin
      waitFrameStart(found);
      testsRun++;
      if (!found) begin
        testsFailed++;
        $display("[TB] FAIL %s_frame_wait frame_start=absent required=pulse", name);
        return;
      end
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clock);
      eSel  = ~(4'b0001 << (k / 4));
      eData = expBytes[8*(k/4) +: 8];
      testsRun++;
      if (sel !== eSel || data !== eData || frameStart !== (k == 0)) begin
        testsFailed++;
        $display("[TB] FAIL %s cycle=%0d sel=%b data=%h fs=%b required sel=%b data=%h fs=%b",
                 name, k, sel, data, frameStart, eSel, eData, (k == 0));
      end
    end
  endtask

  task automatic test_load_midframe;
    bit found;
    int cyc;
    logic [23:0] oldSnap, newSnap;
    oldSnap = {blankIn, dpIn, valueIn};
    newSnap = {4'b0000, 4'($urandom), 16'($urandom)};
    waitFrameStart(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL midframe_wait frame_start=absent required=pulse");
      return;
    end
    cyc = 0;
    repeat (8) begin @(negedge clock); cyc++; end
    testsRun++;
    if (sel !== 4'b1011) begin
      testsFailed++;
      $display("[TB] FAIL midframe_digit2 sel=%b required 1011", sel);
    end
    valueIn = newSnap[15:0]; dpIn = newSnap[19:16]; blankIn = newSnap[23:20]; load = 1'b1;
    found = 1'b0;
    while (!found && cyc < 40) begin
      @(negedge clock);
      load = 1'b0;
      cyc++;
      if (frameStart === 1'b1) found = 1'b1;
      else if (cyc < 16) begin
        testsRun++;
        if (data !== expSeg(oldSnap, cyc / 4)) begin
          testsFailed++;
          $display("[TB] FAIL midframe_old cycle=%0d data=%h required %h", cyc, data, expSeg(oldSnap, cyc / 4));
        end
      end
    end
    testsRun++;
    if (cyc != 16) begin
      testsFailed++;
      $display("[TB] FAIL frame_period cycles=%0d required 16", cyc);
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clock);
      testsRun++;
      if (data !== expSeg(newSnap, k / 4)) begin
        testsFailed++;
        $display("[TB] FAIL midframe_new cycle=%0d data=%h required %h", k, data, expSeg(newSnap, k / 4));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit found;
    logic [23:0] snapA, snapB;
    snapA = {4'b0000, 4'b0000, 16'($urandom)};
    snapB = {4'b0000, 4'b1010, 16'($urandom)};
    waitFrameStart(found);
    @(negedge clock);
    valueIn = snapA[15:0]; dpIn = snapA[19:16]; blankIn = snapA[23:20]; load = 1'b1;
    @(negedge clock);
    valueIn = snapB[15:0]; dpIn = snapB[19:16]; blankIn = snapB[23:20];
    @(negedge clock);
    load = 1'b0;
    waitFrameStart(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL b2b_wait frame_start=absent required=pulse");
      return;
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clock);
      testsRun++;
      if (data !== expSeg(snapB, k / 4)) begin
        testsFailed++;
        $display("[TB] FAIL back_to_back cycle=%0d data=%h required %h", k, data, expSeg(snapB, k / 4));
      end
    end
  endtask

  task automatic test_reset_midscan;
    bit found;
    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      @(negedge clock);
      if (sel === 4'b1011) found = 1'b1;
    end
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL midscan_wait sel=%b required 1011", sel);
      return;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    testsRun++;
    if (sel !== 4'hF || data !== 8'hFF || frameStart !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midscan_reset sel=%h data=%h fs=%b required sel=f data=ff fs=0", sel, data, frameStart);
    end
    waitFrameStart(found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL midscan_frame frame_start=absent required=pulse");
      return;
    end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clock);
      testsRun++;
      if (data !== expSeg(24'h0, k / 4) || (k == 0 && data !== 8'hC0)) begin
        testsFailed++;
        $display("[TB] FAIL midscan_cleared cycle=%0d data=%h required %h", k, data, expSeg(24'h0, k / 4));
      end
    end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) begin
        valueIn = 16'($urandom); dpIn = 4'($urandom); blankIn = 4'($urandom & $urandom);
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      testsRun++;
      if (sel !== mSel || data !== mData || frameStart !== mFs) begin
        testsFailed++;
        $display("[TB] FAIL random cycle=%0d sel=%b data=%h fs=%b required sel=%b data=%h fs=%b",
                 c, sel, data, frameStart, mSel, mData, mFs);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_frame("pattern", 16'h12AF, 4'b0000, 4'b0000, {8'hF9, 8'hA4, 8'h88, 8'h8E});
    test_frame("dp_blank", 16'h12AF, 4'b0001, 4'b0100, {8'hF9, 8'hFF, 8'h88, 8'h0E});
    test_load_midframe();
    test_back_to_back();
    test_reset_midscan();
`ifdef LEADING_ZERO_BLANK_EN
    test_frame("leading_zero", 16'h0005, 4'b0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'h92});
`else
    test_frame("leading_zero", 16'h0005, 4'b0000, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'h92});
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog time_limit reached required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
